fir_mac_sequencer: RTL and testbench

//   Sequences the shared single-multiplier FIR datapath. It accepts one assembled
//   16-bit sample per in_valid/in_ready handshake from the receive side. It then

---
 rtl/fir_mac_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for a time-shared single-multiplier FIR.
// One sample is taken per in_valid/in_ready handshake. The sequence is
// SHIFT (push into delay line, clear accumulator), then MAC (one tap per
// cycle), then DRAIN (flush the multiplier pipeline), then LATCH (load the
// output register), then HOLD (present the result until out_ready).
// All outputs are decoded from registered state. The one exception is
// acc_en, which is mac_issue delayed by the multiplier latency.
// Every output is forced low while rst is asserted.

module fir_mac_sequencer #(
   parameter int TAPS     = 16,
   parameter int MULT_LAT = 1,
   parameter int ADDR_W   = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              shift_en,
   output logic              acc_clr,
   output logic [ADDR_W-1:0] tap_addr,
   output logic              mac_issue,
   output logic              acc_en,
   output logic              out_latch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   // The drain counter needs at least one bit, even when there is no drain phase.
   localparam int DRN_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
   localparam int DRN_INIT = (MULT_LAT > 0) ? (MULT_LAT - 1) : 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_LATCH = 3'd4,
      S_HOLD  = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_tap_cnt;
   logic [DRN_W-1:0]   r_drain_cnt;
   logic               w_tap_last;
   logic               w_mac_dec;
   logic               w_acc_src;

   assign w_tap_last = (r_tap_cnt == ADDR_W'(TAPS - 1));
   assign w_mac_dec  = (r_state == S_MAC);

   // State register: synchronous reset returns to IDLE, which aborts any sample in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. in_valid is only looked at in IDLE, and out_ready only in HOLD.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_next = S_SHIFT;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_SHIFT: w_next = S_MAC;
         S_MAC: begin
            if (w_tap_last) begin
               w_next = (MULT_LAT > 0) ? S_DRAIN : S_LATCH;
            end else begin
               w_next = S_MAC;
            end
         end
         S_DRAIN: begin
            if (r_drain_cnt == DRN_W'(0)) begin
               w_next = S_LATCH;
            end else begin
               w_next = S_DRAIN;
            end
         end
         S_LATCH: w_next = S_HOLD;
         S_HOLD: begin
            if (out_ready) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_HOLD;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Tap and drain counters. Both are loaded or cleared before they could pass their range, so they never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tap_cnt   <= '0;
         r_drain_cnt <= '0;
      end else begin
         case (r_state)
            S_SHIFT: r_tap_cnt <= '0;
            S_MAC: begin
               if (w_tap_last) begin
                  r_tap_cnt   <= '0;
                  r_drain_cnt <= DRN_W'(DRN_INIT);
               end else begin
                  r_tap_cnt <= r_tap_cnt + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt != DRN_W'(0)) begin
                  r_drain_cnt <= r_drain_cnt - DRN_W'(1);
               end
            end
            default: begin
               r_tap_cnt   <= r_tap_cnt;
               r_drain_cnt <= r_drain_cnt;
            end
         endcase
      end
   end

   // acc_en source: mac_issue delayed by MULT_LAT, or a direct pass-through when the multiplier is combinational.
   generate
      if (MULT_LAT == 0) begin : g_nopipe
         assign w_acc_src = w_mac_dec;
      end else begin : g_pipe
         logic [MULT_LAT-1:0] r_issue_pipe;
         // Issue delay line, shifted once per cycle and cleared on reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_issue_pipe <= '0;
            end else begin
               r_issue_pipe <= (r_issue_pipe << 1) | MULT_LAT'(w_mac_dec);
            end
         end
         assign w_acc_src = r_issue_pipe[MULT_LAT-1];
      end
   endgenerate

   // Moore output decode. Every output is held at 0 while rst is high.
   always_comb begin
      in_ready  = 1'b0;
      shift_en  = 1'b0;
      acc_clr   = 1'b0;
      tap_addr  = '0;
      mac_issue = 1'b0;
      acc_en    = 1'b0;
      out_latch = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      if (!rst) begin
         acc_en = w_acc_src;
         busy   = (r_state != S_IDLE);
         case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_SHIFT: begin
               shift_en = 1'b1;
               acc_clr  = 1'b1;
            end
            S_MAC: begin
               mac_issue = 1'b1;
               tap_addr  = r_tap_cnt;
            end
            S_LATCH: out_latch = 1'b1;
            S_HOLD:  out_valid = 1'b1;
            default: begin
               in_ready = 1'b0;
            end
         endcase
      end else begin
         busy = 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer.
// Two instances share clk and rst: u_dut0 has TAPS=4, MULT_LAT=1, and
// u_dut1 has TAPS=4, MULT_LAT=0.
// The stimulus pushes one expectation per sample it expects to complete.
// A monitor follows each accepted sample and checks the whole trace when
// out_valid rises. Latency is counted with the accept edge as edge 1, so
// out_valid rises on edge TAPS+MULT_LAT+3.

module tb_fir_mac_sequencer;

   localparam int TAPS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic iv0 = 1'b0, ordy0 = 1'b1;
   logic iv1 = 1'b0, ordy1 = 1'b1;

   logic       in_ready0, shift0, clr0, issue0, acc0, latch0, ovalid0, busy0;
   logic [1:0] addr0;
   logic       in_ready1, shift1, clr1, issue1, acc1, latch1, ovalid1, busy1;
   logic [1:0] addr1;

   fir_mac_sequencer #(.TAPS(TAPS), .MULT_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(in_ready0),
      .shift_en(shift0), .acc_clr(clr0), .tap_addr(addr0), .mac_issue(issue0),
      .acc_en(acc0), .out_latch(latch0), .out_valid(ovalid0),
      .out_ready(ordy0), .busy(busy0));

   fir_mac_sequencer #(.TAPS(TAPS), .MULT_LAT(0)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1),
      .shift_en(shift1), .acc_clr(clr1), .tap_addr(addr1), .mac_issue(issue1),
      .acc_en(acc1), .out_latch(latch1), .out_valid(ovalid1),
      .out_ready(ordy1), .busy(busy1));

   always #5 clk = ~clk;

   // Per-instance views so that one monitor loop can serve both instances.
   wire [1:0] iv_a     = {iv1, iv0};
   wire [1:0] ready_a  = {in_ready1, in_ready0};
   wire [1:0] shift_a  = {shift1, shift0};
   wire [1:0] issue_a  = {issue1, issue0};
   wire [1:0] acc_a    = {acc1, acc0};
   wire [1:0] latch_a  = {latch1, latch0};
   wire [1:0] ovalid_a = {ovalid1, ovalid0};
   wire [1:0] addr_a [2];
   assign addr_a[0] = addr0;
   assign addr_a[1] = addr1;
   wire [10:0] outs0 = {in_ready0, shift0, clr0, addr0, issue0, acc0, latch0, ovalid0, busy0};
   wire [10:0] outs1 = {in_ready1, shift1, clr1, addr1, issue1, acc1, latch1, ovalid1, busy1};

   typedef struct {
      int inst;
      int lat;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int edge_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Count rising edges so that latencies can be measured in edges.
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor state, one slot per instance.
   bit  trk [2];
   int  t_acc [2];
   int  n_shift [2], n_issue [2], n_acc [2], n_latch [2], n_addr_err [2], n_pipe_err [2];
   bit  prev_valid [2];

   // Monitor: follow each accepted sample, then score it against the queue when out_valid rises.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         prev_valid[g] <= ovalid_a[g];
         if (ovalid_a[g] && !prev_valid[g]) begin
            if (sb_q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_instance", g, e.inst);
               check("sb_tracked", int'(trk[g]), 1);
               check("sb_latency", edge_cnt - t_acc[g] + 1, e.lat);
               check("sb_shift_pulses", n_shift[g], 1);
               check("sb_issue_cycles", n_issue[g], TAPS);
               check("sb_acc_pulses", n_acc[g], TAPS);
               check("sb_latch_pulses", n_latch[g], 1);
               check("sb_tap_addr_seq", n_addr_err[g], 0);
               if (g == 1) check("sb_acc_eq_issue", n_pipe_err[g], 0);
            end
            trk[g] <= 1'b0;
         end else if (rst) begin
            trk[g] <= 1'b0;
         end else if (iv_a[g] && ready_a[g]) begin
            trk[g]        <= 1'b1;
            t_acc[g]      <= edge_cnt + 1;
            n_shift[g]    <= 0;
            n_issue[g]    <= 0;
            n_acc[g]      <= 0;
            n_latch[g]    <= 0;
            n_addr_err[g] <= 0;
            n_pipe_err[g] <= 0;
         end else if (trk[g]) begin
            n_shift[g] <= n_shift[g] + int'(shift_a[g]);
            n_issue[g] <= n_issue[g] + int'(issue_a[g]);
            n_acc[g]   <= n_acc[g] + int'(acc_a[g]);
            n_latch[g] <= n_latch[g] + int'(latch_a[g]);
            if (issue_a[g] ? (int'(addr_a[g]) != n_issue[g]) : (addr_a[g] != 2'd0))
               n_addr_err[g] <= n_addr_err[g] + 1;
            if (acc_a[g] != issue_a[g])
               n_pipe_err[g] <= n_pipe_err[g] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_sample(input int g, input int mult_lat);
      exp_t e;
      e.inst = g;
      e.lat  = TAPS + mult_lat + 3;
      sb_q.push_back(e);
   endtask

   task automatic wait_valid(input int g, input int budget);
      bit got;
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk);
         if (ovalid_a[g]) got = 1'b1;
      end
      check("wait_out_valid_timeout", int'(got), 1);
   endtask

   task automatic pulse_iv0();
      iv0 = 1'b1;
      tick();
      iv0 = 1'b0;
   endtask

   initial begin
      int acc_e [3];
      int n;
      bit hit;

      // Reset: every output must be 0 while rst is high, in_ready included.
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("reset_outs_dut0", int'(outs0), 0);
      check("reset_outs_dut1", int'(outs1), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready_dut0", int'(in_ready0), 1);
      check("idle_busy_dut0", int'(busy0), 0);

      // T1: a single sample with out_ready held high.
      tick();
      expect_sample(0, 1);
      pulse_iv0();
      wait_valid(0, 30);
      repeat (3) tick();

      // T2: out_ready held low, and a second in_valid arrives during HOLD.
      ordy0 = 1'b0;
      expect_sample(0, 1);
      pulse_iv0();
      wait_valid(0, 30);
      for (int c = 0; c < 20; c++) begin
         tick();
         iv0 = 1'b1;
         @(negedge clk);
         check("t2_hold_out_valid", int'(ovalid0), 1);
         check("t2_hold_in_ready", int'(in_ready0), 0);
      end
      tick();
      iv0   = 1'b0;
      ordy0 = 1'b1;
      tick();
      @(negedge clk);
      check("t2_back_idle_in_ready", int'(in_ready0), 1);
      check("t2_back_idle_out_valid", int'(ovalid0), 0);
      repeat (2) tick();

      // T3: MULT_LAT=0, so there is no drain phase and acc_en follows mac_issue.
      expect_sample(1, 0);
      iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      wait_valid(1, 30);
      repeat (3) tick();

      // T4: in_valid and out_ready held high, giving one accept every TAPS+MULT_LAT+4 cycles.
      repeat (3) expect_sample(0, 1);
      n = 0;
      iv0 = 1'b1;
      for (int c = 0; c < 60 && n < 3; c++) begin
         @(negedge clk);
         if (in_ready0) begin
            acc_e[n] = edge_cnt + 1;
            n++;
         end
      end
      tick();
      iv0 = 1'b0;
      check("t4_accept_count", n, 3);
      if (n == 3) begin
         check("t4_period_1", acc_e[1] - acc_e[0], TAPS + 1 + 4);
         check("t4_period_2", acc_e[2] - acc_e[1], TAPS + 1 + 4);
      end
      wait_valid(0, 30);
      repeat (3) tick();

      // T5: reset while tap_addr=2 is in MAC. The sample is aborted and no out_valid may follow.
      pulse_iv0();
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk);
         if (issue0 && addr0 == 2'd1) hit = 1'b1;
      end
      check("t5_reached_tap1", int'(hit), 1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_outs_dut0", int'(outs0), 0);
      check("t5_rst_outs_dut1", int'(outs1), 0);
      tick();
      @(negedge clk);
      check("t5_rst_outs_dut0_b", int'(outs0), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t5_after_rst_in_ready", int'(in_ready0), 1);
      check("t5_after_rst_busy", int'(busy0), 0);
      repeat (12) tick();
      @(negedge clk);
      check("t5_no_out_valid", int'(ovalid0), 0);
      tick();
      expect_sample(0, 1);
      pulse_iv0();
      wait_valid(0, 30);
      repeat (3) tick();

      // T6: out_ready and in_valid arrive together in HOLD. The FSM goes to IDLE for one cycle, then accepts.
      ordy0 = 1'b0;
      expect_sample(0, 1);
      expect_sample(0, 1);
      pulse_iv0();
      wait_valid(0, 30);
      tick();
      ordy0 = 1'b1;
      iv0   = 1'b1;
      @(negedge clk);
      check("t6_still_hold", int'(ovalid0), 1);
      check("t6_hold_in_ready", int'(in_ready0), 0);
      tick();
      @(negedge clk);
      check("t6_idle_in_ready", int'(in_ready0), 1);
      check("t6_idle_busy", int'(busy0), 0);
      check("t6_idle_no_shift", int'(shift0), 0);
      tick();
      iv0 = 1'b0;
      @(negedge clk);
      check("t6_shift_en", int'(shift0), 1);
      check("t6_acc_clr", int'(clr0), 1);
      wait_valid(0, 30);
      repeat (4) tick();

      check("sb_pending_at_end", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog: guarantees the run terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
